// File: rtl/efuse_pkg.sv
// Shared types, constants and address decode for the eFuse sequencer/arbiter.
package efuse_pkg;

  localparam int unsigned EFUSE_NR       = 64;
  localparam int unsigned EFUSE_RSEL     = 4;
  localparam int unsigned EFUSE_BYTE_NUM = EFUSE_NR / 8;

  typedef enum logic [3:0] {
    BOOT_ISS,
    BOOT_WAIT,
    IDLE,
    RD_ISS,
    RD_WAIT,
    PGM_ISS,
    PGM_WAIT,
    REFR_ISS,
    REFR_WAIT
  } efuse_arb_st_e;

  // Byte address -> read segment index; may exceed the segment count for bad addresses.
  function automatic logic [7:0] pgm_addr_to_seg(input logic [7:0] addr,
                                                 input int unsigned byte_num);
    return 8'(32'(addr) / byte_num);
  endfunction

endpackage

// File: rtl/efuse_ctrl_arb_if.sv
// Software request/acknowledge bus between the requester and the eFuse arbiter.
interface efuse_ctrl_arb_if
  import efuse_pkg::*;
#(
  parameter  int unsigned NR    = EFUSE_NR,
  parameter  int unsigned RSEL  = EFUSE_RSEL,
  localparam int unsigned SEL_W = $clog2(RSEL)
);

  logic             sw_rd_req;
  logic [SEL_W-1:0] sw_rd_sel;
  logic             sw_pgm_req;
  logic [7:0]       sw_pgm_addr;
  logic [2:0]       sw_pgm_bit;
  logic             sw_ack;
  logic             sw_err;
  logic [NR-1:0]    sw_rd_data;

  modport master (
    output sw_rd_req, sw_rd_sel, sw_pgm_req, sw_pgm_addr, sw_pgm_bit,
    input  sw_ack, sw_err, sw_rd_data
  );

  modport slave (
    input  sw_rd_req, sw_rd_sel, sw_pgm_req, sw_pgm_addr, sw_pgm_bit,
    output sw_ack, sw_err, sw_rd_data
  );

endinterface

// File: rtl/efuse_wdog.sv
// Engine watchdog: cleared on issue, counts while waiting, saturates at all-ones.
module efuse_wdog #(
  parameter int unsigned W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [W-1:0] cnt;

  assign expire_c = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire_c) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/efuse_ctrl_arb.sv
// Boot-loads the fuse shadow, then serializes software read/program requests
// to the eFuse engines with read priority and a timeout watchdog.
module efuse_ctrl_arb
  import efuse_pkg::*;
#(
  parameter  int unsigned NR    = EFUSE_NR,
  parameter  int unsigned RSEL  = EFUSE_RSEL,
  parameter  int unsigned TMO_W = 10,
  localparam int unsigned SEL_W = $clog2(RSEL)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  efuse_ctrl_arb_if.slave      sw,
  output logic [NR*RSEL-1:0]   shadow,
  output logic                 load_done,
  output logic                 tmo_err,
  output logic                 busy,
  output logic                 rd_start,
  output logic [SEL_W-1:0]     rd_sel,
  input  logic                 rd_done,
  input  logic [NR-1:0]        rd_data,
  output logic                 pgm_start,
  output logic [7:0]           pgm_addr,
  output logic [2:0]           pgm_bit,
  input  logic                 pgm_done
);

  efuse_arb_st_e    state, state_d;
  logic [SEL_W-1:0] seg_cnt;
  logic [7:0]       pgm_seg;
  logic             pgm_seg_ok;
  logic             wd_clr, wd_en, wd_exp;
  logic             shadow_we, data_we, ack_d, err_d, tmo_set;
  logic             seg_adv, load_set, take_rd, take_pgm;

  assign pgm_seg    = pgm_addr_to_seg(sw.sw_pgm_addr, NR / 8);
  assign pgm_seg_ok = 32'(pgm_seg) < RSEL;

  assign wd_clr    = state inside {BOOT_ISS, RD_ISS, PGM_ISS, REFR_ISS};
  assign wd_en     = state inside {BOOT_WAIT, RD_WAIT, PGM_WAIT, REFR_WAIT};
  // Gated by rst_n so the reset state (BOOT_ISS) does not start the engine while held in reset.
  assign rd_start  = rst_n && (state inside {BOOT_ISS, RD_ISS, REFR_ISS});
  assign pgm_start = (state == PGM_ISS);
  assign busy      = (state != IDLE);

  efuse_wdog #(.W(TMO_W)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr),
    .en       (wd_en),
    .expire_c (wd_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT_ISS;
    else        state <= state_d;
  end

  // Next state and one-cycle control strobes for the datapath.
  always_comb begin
    state_d   = state;
    shadow_we = 1'b0;
    data_we   = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    tmo_set   = 1'b0;
    seg_adv   = 1'b0;
    load_set  = 1'b0;
    take_rd   = 1'b0;
    take_pgm  = 1'b0;
    case (state)
      BOOT_ISS: state_d = BOOT_WAIT;
      BOOT_WAIT: begin
        if (rd_done || wd_exp) begin
          shadow_we = rd_done;
          tmo_set   = !rd_done;
          if (seg_cnt == SEL_W'(RSEL - 1)) begin
            load_set = 1'b1;
            state_d  = IDLE;
          end else begin
            seg_adv = 1'b1;
            state_d = BOOT_ISS;
          end
        end
      end
      IDLE: begin
        // The ack cycle is skipped so a still-high level request is not served twice.
        if (!sw.sw_ack) begin
          if (sw.sw_rd_req) begin
            take_rd = 1'b1;
            state_d = RD_ISS;
          end else if (sw.sw_pgm_req) begin
            if (pgm_seg_ok) begin
              take_pgm = 1'b1;
              state_d  = PGM_ISS;
            end else begin
              ack_d = 1'b1;
              err_d = 1'b1;
            end
          end
        end
      end
      RD_ISS: state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_done) begin
          shadow_we = 1'b1;
          data_we   = 1'b1;
          ack_d     = 1'b1;
          state_d   = IDLE;
        end else if (wd_exp) begin
          tmo_set = 1'b1;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      PGM_ISS: state_d = PGM_WAIT;
      PGM_WAIT: begin
        if (pgm_done) begin
          state_d = REFR_ISS;
        end else if (wd_exp) begin
          tmo_set = 1'b1;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      REFR_ISS: state_d = REFR_WAIT;
      REFR_WAIT: begin
        if (rd_done) begin
          shadow_we = 1'b1;
          ack_d     = 1'b1;
          state_d   = IDLE;
        end else if (wd_exp) begin
          tmo_set = 1'b1;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = BOOT_ISS;
    endcase
  end

  // rd_sel tracks seg_cnt during boot, so one write port serves boot, read and refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow        <= '0;
      sw.sw_rd_data <= '0;
      sw.sw_ack     <= 1'b0;
      sw.sw_err     <= 1'b0;
      seg_cnt       <= '0;
      load_done     <= 1'b0;
      tmo_err       <= 1'b0;
      rd_sel        <= '0;
      pgm_addr      <= '0;
      pgm_bit       <= '0;
    end else begin
      sw.sw_ack <= ack_d;
      sw.sw_err <= err_d;
      if (tmo_set)   tmo_err   <= 1'b1;
      if (load_set)  load_done <= 1'b1;
      if (shadow_we) shadow[32'(rd_sel)*NR +: NR] <= rd_data;
      if (data_we)   sw.sw_rd_data <= rd_data;
      if (seg_adv) begin
        seg_cnt <= seg_cnt + SEL_W'(1);
        rd_sel  <= seg_cnt + SEL_W'(1);
      end
      if (take_rd) rd_sel <= sw.sw_rd_sel;
      if (take_pgm) begin
        rd_sel   <= SEL_W'(pgm_seg);
        pgm_addr <= sw.sw_pgm_addr;
        pgm_bit  <= sw.sw_pgm_bit;
      end
    end
  end

endmodule

// File: tb/tb_efuse_ctrl_arb.sv
// Randomized bench for efuse_ctrl_arb: engine models over a fuse array plus a
// shadow/readback reference model kept at the fuse-array level.
module tb_efuse_ctrl_arb;
  import efuse_pkg::*;

  localparam int unsigned NR    = 64;
  localparam int unsigned RSEL  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned TMO_W = 10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NR*RSEL-1:0]  shadow;
  logic                load_done, tmo_err, busy;
  logic                rd_start, rd_done, pgm_start, pgm_done;
  logic [SEL_W-1:0]    rd_sel;
  logic [NR-1:0]       rd_data;
  logic [7:0]          pgm_addr;
  logic [2:0]          pgm_bit;

  efuse_ctrl_arb_if sw ();

  efuse_ctrl_arb #(.NR(NR), .RSEL(RSEL), .TMO_W(TMO_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .shadow    (shadow),
    .load_done (load_done),
    .tmo_err   (tmo_err),
    .busy      (busy),
    .rd_start  (rd_start),
    .rd_sel    (rd_sel),
    .rd_done   (rd_done),
    .rd_data   (rd_data),
    .pgm_start (pgm_start),
    .pgm_addr  (pgm_addr),
    .pgm_bit   (pgm_bit),
    .pgm_done  (pgm_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Fuse array: software-visible initial content plus bits burnt by the program engine.
  bit [255:0]  fuse_init;
  bit [255:0]  burnt;
  wire [255:0] view = fuse_init | burnt;

  int               rd_lat, pgm_lat;
  bit               rd_hang;
  logic             rd_act, pgm_act;
  int               rd_left, pgm_left;
  logic [SEL_W-1:0] rd_cur, rd_last_sel;
  int               rd_starts, pgm_starts;
  logic [7:0]       pgm_cur_addr;
  logic [2:0]       pgm_cur_bit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_done     <= 1'b0;
      rd_data     <= '0;
      rd_act      <= 1'b0;
      rd_left     <= 0;
      rd_cur      <= '0;
      rd_last_sel <= '1;
      rd_starts   <= 0;
    end else if (rd_start) begin
      rd_done     <= 1'b0;
      rd_act      <= 1'b1;
      rd_left     <= rd_lat;
      rd_cur      <= rd_sel;
      rd_last_sel <= rd_sel;
      rd_starts   <= rd_starts + 1;
    end else if (rd_act && !rd_hang) begin
      if (rd_left == 0) begin
        rd_done <= 1'b1;
        rd_data <= view[32'(rd_cur)*64 +: 64];
        rd_act  <= 1'b0;
      end else begin
        rd_left <= rd_left - 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pgm_done     <= 1'b0;
      pgm_act      <= 1'b0;
      pgm_left     <= 0;
      pgm_cur_addr <= '0;
      pgm_cur_bit  <= '0;
      pgm_starts   <= 0;
    end else if (pgm_start) begin
      pgm_done     <= 1'b0;
      pgm_act      <= 1'b1;
      pgm_left     <= pgm_lat;
      pgm_cur_addr <= pgm_addr;
      pgm_cur_bit  <= pgm_bit;
      pgm_starts   <= pgm_starts + 1;
    end else if (pgm_act) begin
      if (pgm_left == 0) begin
        if (pgm_cur_addr < 8'd32) burnt[32'(pgm_cur_addr)*8 + 32'(pgm_cur_bit)] <= 1'b1;
        pgm_done <= 1'b1;
        pgm_act  <= 1'b0;
      end else begin
        pgm_left <= pgm_left - 1;
      end
    end
  end

  int   ack_cnt = 0;
  int   dbl     = 0;
  logic prev_rs = 1'b0;
  logic prev_ps = 1'b0;

  always @(negedge clk) begin
    if (sw.sw_ack === 1'b1) ack_cnt++;
    if ((rd_start && prev_rs) || (pgm_start && prev_ps)) dbl++;
    prev_rs = rd_start;
    prev_ps = pgm_start;
  end

  logic [255:0] exp_sh, exp_burnt;
  logic [63:0]  exp_rd;
  logic         exp_tmo;

  function automatic logic [63:0] fuse_seg(input int k);
    logic [255:0] fv;
    fv = fuse_init | exp_burnt;
    return fv[k*64 +: 64];
  endfunction

  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (sw.sw_ack === 1'b1) break;
    end
    check("ack_seen", sw.sw_ack, 1'b1);
  endtask

  task automatic wait_load(input int budget);
    int n;
    n = 0;
    while (n < budget && load_done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("load_done", load_done, 1'b1);
  endtask

  task automatic do_read(input int sel, input bit hang);
    int cyc;
    @(negedge clk);
    sw.sw_rd_sel = SEL_W'(sel);
    sw.sw_rd_req = 1'b1;
    @(negedge clk);
    check("rd_start", rd_start, 1'b1);
    check("rd_sel", rd_sel, sel);
    wait_ack(hang ? 1200 : 100, cyc);
    if (hang) begin
      exp_tmo = 1'b1;
      check("tmo_cycles", (cyc >= 1015) && (cyc <= 1030), 1'b1);
    end else begin
      exp_rd = fuse_seg(sel);
      exp_sh[sel*64 +: 64] = exp_rd;
    end
    check("rd_err", sw.sw_err, hang);
    check("rd_data", sw.sw_rd_data, exp_rd);
    check("rd_shadow", shadow, exp_sh);
    check("rd_tmo_err", tmo_err, exp_tmo);
    sw.sw_rd_req = 1'b0;
  endtask

  task automatic do_pgm(input int addr, input int bitn);
    int cyc, seg;
    @(negedge clk);
    sw.sw_pgm_addr = 8'(addr);
    sw.sw_pgm_bit  = 3'(bitn);
    sw.sw_pgm_req  = 1'b1;
    @(negedge clk);
    if (addr < 32) begin
      seg = addr / 8;
      check("pgm_start", pgm_start, 1'b1);
      check("pgm_addr", pgm_addr, addr);
      check("pgm_bit", pgm_bit, bitn);
      wait_ack(200, cyc);
      exp_burnt[addr*8 + bitn] = 1'b1;
      exp_sh[seg*64 +: 64] = fuse_seg(seg);
      check("pgm_err", sw.sw_err, 1'b0);
      check("refr_sel", rd_last_sel, seg);
    end else begin
      check("bad_ack", sw.sw_ack, 1'b1);
      check("bad_err", sw.sw_err, 1'b1);
      check("bad_no_start", pgm_start, 1'b0);
    end
    check("pgm_shadow", shadow, exp_sh);
    check("pgm_rd_data_keep", sw.sw_rd_data, exp_rd);
    sw.sw_pgm_req = 1'b0;
  endtask

  initial begin
    int cyc, a0, p0;
    rst_n          = 1'b0;
    sw.sw_rd_req   = 1'b0;
    sw.sw_rd_sel   = '0;
    sw.sw_pgm_req  = 1'b0;
    sw.sw_pgm_addr = '0;
    sw.sw_pgm_bit  = '0;
    rd_lat = 2; pgm_lat = 3; rd_hang = 1'b0;
    for (int k = 0; k < 4; k++) fuse_init[k*64 +: 64] = {16{4'(k + 1)}};
    exp_burnt = '0; exp_sh = '0; exp_rd = '0; exp_tmo = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_shadow", shadow, '0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_tmo_err", tmo_err, 1'b0);
    check("rst_ack", sw.sw_ack, 1'b0);
    check("rst_err", sw.sw_err, 1'b0);
    check("rst_rd_start", rd_start, 1'b0);
    check("rst_pgm_start", pgm_start, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_rd_data", sw.sw_rd_data, '0);

    rst_n = 1'b1;
    #1 check("boot_first_start", rd_start, 1'b1);
    wait_load(300);
    check("boot_shadow", shadow, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    check("boot_reads", rd_starts, 4);
    check("boot_no_ack", ack_cnt, 0);
    check("boot_idle", busy, 1'b0);
    exp_sh = fuse_init;

    fuse_init[128 +: 64] = 64'hDEADBEEF_CAFEF00D;
    do_read(2, 1'b0);
    check("deadbeef", sw.sw_rd_data, 64'hDEADBEEF_CAFEF00D);

    do_pgm(8'h13, 5);
    check("pgm13_seg2", shadow[191:128], 64'hDEADBEEF_EAFEF00D);
    do_pgm(8'h40, 1);

    // Simultaneous requests: read first, program after the ack gap.
    a0 = ack_cnt; p0 = pgm_starts;
    fuse_init[64 +: 64] = {$urandom, $urandom};
    @(negedge clk);
    sw.sw_rd_sel = 2'd1; sw.sw_rd_req = 1'b1;
    sw.sw_pgm_addr = 8'h05; sw.sw_pgm_bit = 3'd3; sw.sw_pgm_req = 1'b1;
    @(negedge clk);
    check("sim_rd_first", rd_start, 1'b1);
    check("sim_no_pgm", pgm_start, 1'b0);
    wait_ack(100, cyc);
    exp_rd = fuse_seg(1);
    exp_sh[64 +: 64] = exp_rd;
    check("sim_rd_data", sw.sw_rd_data, exp_rd);
    check("sim_pgm_pending", pgm_starts, p0);
    sw.sw_rd_req = 1'b0;
    @(negedge clk);
    check("sim_ack_gap", pgm_start, 1'b0);
    @(negedge clk);
    check("sim_pgm_start", pgm_start, 1'b1);
    check("sim_pgm_addr", pgm_addr, 8'h05);
    wait_ack(200, cyc);
    exp_burnt[5*8 + 3] = 1'b1;
    exp_sh[0 +: 64] = fuse_seg(0);
    check("sim_shadow", shadow, exp_sh);
    check("sim_two_acks", ack_cnt - a0, 2);
    sw.sw_pgm_req = 1'b0;

    for (int i = 0; i < 24; i++) begin
      int sel;
      rd_lat  = $urandom_range(0, 5);
      pgm_lat = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 0) begin
        sel = $urandom_range(0, 3);
        fuse_init[sel*64 +: 64] = {$urandom, $urandom};
        do_read(sel, 1'b0);
      end else begin
        do_pgm($urandom_range(0, 39), $urandom_range(0, 7));
      end
    end

    rd_hang = 1'b1;
    do_read(3, 1'b1);
    rd_hang = 1'b0;
    do_read(0, 1'b0);

    // Reset during PGM_WAIT aborts the program and restarts the boot load.
    pgm_lat = 40;
    @(negedge clk);
    sw.sw_pgm_addr = 8'h1A; sw.sw_pgm_bit = 3'd2; sw.sw_pgm_req = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    sw.sw_pgm_req = 1'b0;
    #1;
    check("mid_rst_shadow", shadow, '0);
    check("mid_rst_rd_data", sw.sw_rd_data, '0);
    check("mid_rst_load", load_done, 1'b0);
    check("mid_rst_tmo", tmo_err, 1'b0);
    check("mid_rst_ack", sw.sw_ack, 1'b0);
    check("mid_rst_pgm_start", pgm_start, 1'b0);
    check("mid_rst_rd_start", rd_start, 1'b0);
    check("mid_rst_busy", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reboot_start", rd_start, 1'b1);
    @(posedge clk);
    #1 check("reboot_seg0", rd_last_sel, 0);
    rd_lat = 1;
    wait_load(300);
    exp_sh  = fuse_init | exp_burnt;
    exp_rd  = '0;
    exp_tmo = 1'b0;
    check("reboot_shadow", shadow, exp_sh);
    check("reboot_tmo", tmo_err, 1'b0);
    check("reboot_rd_data", sw.sw_rd_data, '0);
    do_read(3, 1'b0);

    check("start_pulse_width", dbl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
